// File: rtl/alu_pkg.sv
// Shared definitions for the wide bit-serial ALU: opcode encoding, opcode
// classification helpers and flag indices.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_ADC = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_MOV = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    FLAG_C = 2'd0,
    FLAG_V = 2'd1,
    FLAG_S = 2'd2,
    FLAG_Z = 2'd3
  } flag_idx_e;

  function automatic logic op_is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
  endfunction

  function automatic logic op_uses_carry(input alu_op_e op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

  function automatic logic op_is_sub(input alu_op_e op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational NSHIFT-bit ALU slice: adder/subtractor with carry-out and
// signed-overflow, plus bitwise ops and pass-through of arg2.
module serial_alu_slice
  import alu_pkg::*;
#(
  parameter int NSHIFT = 2
) (
  input  alu_op_e           op,
  input  logic [NSHIFT-1:0] a,
  input  logic [NSHIFT-1:0] b,
  input  logic              cin,
  output logic [NSHIFT-1:0] y,
  output logic              cout,
  output logic              ovf
);

  logic [NSHIFT-1:0] b_eff;
  logic [NSHIFT:0]   sum;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    b_eff = op_is_sub(op) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{NSHIFT{1'b0}}, cin};
    y     = sum[NSHIFT-1:0];
    cout  = 1'b0;
    ovf   = 1'b0;
    if (op_is_arith(op)) begin
      cout = sum[NSHIFT];
      ovf  = (a[NSHIFT-1] == b_eff[NSHIFT-1]) && (sum[NSHIFT-1] != a[NSHIFT-1]);
    end else begin
      case (op)
        OP_AND:  y = a & b;
        OP_OR:   y = a | b;
        OP_XOR:  y = a ^ b;
        default: y = b;
      endcase
    end
  end

endmodule

// File: rtl/serial_alu_wide.sv
// Bit-serial ALU: consumes one NSHIFT-bit chunk per enabled cycle, LSB first,
// over 1..MAX_REGS registers, with arg2 extension and end-of-op flag update.
module serial_alu_wide
  import alu_pkg::*;
#(
  parameter int NSHIFT   = 2,
  parameter int REG_BITS = 8,
  parameter int MAX_REGS = 4,
  parameter int LEN_BITS = $clog2(MAX_REGS),
  parameter int CNT_BITS = $clog2(MAX_REGS * REG_BITS / NSHIFT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [LEN_BITS-1:0] len,
  input  logic [LEN_BITS-1:0] arg2_len,
  input  logic                sext2,
  input  logic                update_flags,
  input  logic                step_en,
  input  logic [NSHIFT-1:0]   data_in1,
  input  logic [NSHIFT-1:0]   data_in2,
  output logic [NSHIFT-1:0]   data_out,
  output logic                out_valid,
  output logic                busy,
  output logic                done,
  output logic [CNT_BITS-1:0] counter,
  output logic                flag_c,
  output logic                flag_v,
  output logic                flag_s,
  output logic                flag_z
);

  localparam int CHUNKS = REG_BITS / NSHIFT;
  localparam int SW     = CNT_BITS + 1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e              state_q, state_d;
  alu_op_e             op_q;
  logic [LEN_BITS-1:0] len_q, a2len_q;
  logic                sext_q, upd_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                carry_q, zero_q, sign_q;
  logic [3:0]          flags_q;

  logic [SW-1:0]       last_step, a2_steps, cnt_w;
  logic                first, is_last, ext_active, cin, cout, ovf, zero_next;
  logic [NSHIFT-1:0]   arg2_chunk;

  // Step bounds are compared one bit wider so MAX_REGS*CHUNKS itself fits.
  assign cnt_w      = {1'b0, cnt_q};
  assign last_step  = SW'((int'(len_q) + 1) * CHUNKS - 1);
  assign a2_steps   = SW'((int'(a2len_q) + 1) * CHUNKS);
  assign first      = (cnt_q == '0);
  assign is_last    = (cnt_w == last_step);
  assign ext_active = (cnt_w >= a2_steps);
  assign arg2_chunk = ext_active ? (sext_q ? {NSHIFT{sign_q}} : '0) : data_in2;

  assign busy      = (state_q == S_RUN);
  assign out_valid = busy && step_en;
  assign done      = out_valid && is_last;
  assign counter   = cnt_q;
  assign zero_next = (first ? 1'b1 : zero_q) && (data_out == '0);

  assign flag_c = flags_q[FLAG_C];
  assign flag_v = flags_q[FLAG_V];
  assign flag_s = flags_q[FLAG_S];
  assign flag_z = flags_q[FLAG_Z];

  always_comb begin
    cin = carry_q;
    if (first) begin
      case (op_q)
        OP_SUB:         cin = 1'b1;
        OP_ADC, OP_SBC: cin = flags_q[FLAG_C];
        default:        cin = 1'b0;
      endcase
    end
  end

  serial_alu_slice #(.NSHIFT(NSHIFT)) u_slice (
    .op   (op_q),
    .a    (data_in1),
    .b    (arg2_chunk),
    .cin  (cin),
    .y    (data_out),
    .cout (cout),
    .ovf  (ovf)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      default: if (done)  state_d = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking '<=' so every flop samples the
  // pre-edge values and ordering between statements cannot matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      len_q   <= '0;
      a2len_q <= '0;
      sext_q  <= 1'b0;
      upd_q   <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && start) begin
        op_q    <= alu_op_e'(op);
        len_q   <= len;
        a2len_q <= (arg2_len > len) ? len : arg2_len;
        sext_q  <= sext2;
        upd_q   <= update_flags;
      end
      if (out_valid) begin
        cnt_q   <= is_last ? '0 : cnt_q + 1'b1;
        carry_q <= cout;
        zero_q  <= zero_next;
        // Remember the MSB of the last real arg2 chunk for sign extension.
        if (cnt_w == a2_steps - SW'(1)) sign_q <= data_in2[NSHIFT-1];
        if (is_last && upd_q) begin
          flags_q[FLAG_C] <= cout;
          flags_q[FLAG_V] <= ovf;
          flags_q[FLAG_S] <= data_out[NSHIFT-1];
          flags_q[FLAG_Z] <= zero_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_wide.sv
// Self-checking bench for serial_alu_wide: directed vector table, handshake
// corner sequences, and randomized ops against a whole-word arithmetic model.
module tb_serial_alu_wide;
  import alu_pkg::*;

  localparam int NSHIFT   = 2;
  localparam int REG_BITS = 8;
  localparam int MAX_REGS = 4;
  localparam int LEN_BITS = 2;
  localparam int CNT_BITS = 4;

  logic                clk = 1'b0;
  logic                reset, start, sext2, update_flags, step_en;
  logic [2:0]          op;
  logic [LEN_BITS-1:0] len, arg2_len;
  logic [NSHIFT-1:0]   data_in1, data_in2, data_out;
  logic                out_valid, busy, done;
  logic [CNT_BITS-1:0] counter;
  logic                flag_c, flag_v, flag_s, flag_z;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  m_flags;
  logic [31:0] cur_a1, cur_a2;
  int          cur_steps, cur_a2steps;

  typedef struct {
    logic [2:0]  op;
    int          len;
    int          a2len;
    bit          sx;
    int          mode;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[10];

  serial_alu_wide #(
    .NSHIFT(NSHIFT), .REG_BITS(REG_BITS), .MAX_REGS(MAX_REGS),
    .LEN_BITS(LEN_BITS), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .len(len),
    .arg2_len(arg2_len), .sext2(sext2), .update_flags(update_flags),
    .step_en(step_en), .data_in1(data_in1), .data_in2(data_in2),
    .data_out(data_out), .out_valid(out_valid), .busy(busy), .done(done),
    .counter(counter), .flag_c(flag_c), .flag_v(flag_v), .flag_s(flag_s),
    .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-word reference: fl = {Z, S, V, C}.
  function automatic void model(input logic [2:0] mop, input int l, input int a2l,
                                input bit sx, input logic cflag,
                                input logic [31:0] a1, input logic [31:0] a2,
                                output logic [31:0] res, output logic [3:0] fl);
    longint unsigned mask, vmask, x, y, b, sum, r, cin;
    logic c, v;
    int wi, vi;
    wi    = (l + 1) * REG_BITS;
    vi    = (((a2l > l) ? l : a2l) + 1) * REG_BITS;
    mask  = (64'd1 << wi) - 1;
    vmask = (64'd1 << vi) - 1;
    x     = 64'(a1) & mask;
    y     = 64'(a2) & vmask;
    if (sx && (((y >> (vi - 1)) & 1) != 0)) y = y | (mask & ~vmask);
    c = 1'b0;
    v = 1'b0;
    case (mop)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        b   = (mop == OP_SUB || mop == OP_SBC) ? (~y & mask) : y;
        cin = (mop == OP_ADD) ? 0 : (mop == OP_SUB) ? 1 : 64'(cflag);
        sum = x + b + cin;
        r   = sum & mask;
        c   = ((sum >> wi) & 1) != 0;
        v   = ((((x ^ b) >> (wi - 1)) & 1) == 0) && ((((r ^ x) >> (wi - 1)) & 1) != 0);
      end
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      default: r = y;
    endcase
    res = r[31:0];
    fl  = {r == 0, ((r >> (wi - 1)) & 1) != 0, v, c};
  endfunction

  // Called at posedge+1 with the DUT idle; leaves the DUT in RUN at posedge+1.
  task automatic begin_op(input vec_t v, input bit upd, input bit hold);
    op           = v.op;
    len          = LEN_BITS'(v.len);
    arg2_len     = LEN_BITS'(v.a2len);
    sext2        = v.sx;
    update_flags = upd;
    step_en      = 1'b0;
    start        = 1'b1;
    cur_a1       = v.a1;
    cur_a2       = v.a2;
    cur_steps    = (v.len + 1) * (REG_BITS / NSHIFT);
    cur_a2steps  = (((v.a2len > v.len) ? v.len : v.a2len) + 1) * (REG_BITS / NSHIFT);
    @(negedge clk);
    check("idle_before_start", busy, 1'b0);
    @(posedge clk); #1;
    start = hold;
  endtask

  task automatic run_steps(input int mode, input int stop_at, output logic [31:0] got);
    int k   = 0;
    int cyc = 0;
    logic [31:0] g = '0;
    while (k < stop_at && cyc < 200) begin
      step_en  = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      data_in1 = cur_a1[k*NSHIFT +: NSHIFT];
      data_in2 = (k >= cur_a2steps) ? NSHIFT'($urandom) : cur_a2[k*NSHIFT +: NSHIFT];
      @(negedge clk);
      check("busy_run", busy, 1'b1);
      check("counter", counter, k);
      check("out_valid", out_valid, step_en);
      if (step_en) begin
        g[k*NSHIFT +: NSHIFT] = data_out;
        check("done_step", done, k == cur_steps - 1);
        k++;
      end else begin
        check("done_stalled", done, 1'b0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    step_en = 1'b0;
    if (k < stop_at) check("step_timeout", k, stop_at);
    got = g;
  endtask

  function automatic logic [3:0] dut_flags();
    return {flag_z, flag_s, flag_v, flag_c};
  endfunction

  // Full operation; returns at the negedge after done (DUT idle).
  task automatic do_op(input vec_t v, input bit upd, output logic [31:0] got,
                       output logic [3:0] fl);
    begin_op(v, upd, 1'b0);
    run_steps(v.mode, cur_steps, got);
    @(negedge clk);
    check("idle_after_done", busy, 1'b0);
    fl = dut_flags();
  endtask

  initial begin
    logic [31:0] got, mres;
    logic [3:0]  fl, mfl;
    vec_t        v;

    vecs[0] = '{OP_ADD, 1, 1, 1'b0, 0, 32'h0000_12FF, 32'h0000_0001, 32'h0000_1300, 4'b0000};
    vecs[1] = '{OP_SUB, 3, 3, 1'b0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 4'b1001};
    vecs[2] = '{OP_SBC, 0, 0, 1'b0, 2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b1001};
    vecs[3] = '{OP_ADD, 1, 0, 1'b1, 0, 32'h0000_0100, 32'h0000_0080, 32'h0000_0080, 4'b0001};
    vecs[4] = '{OP_ADD, 1, 0, 1'b0, 0, 32'h0000_0100, 32'h0000_0080, 32'h0000_0180, 4'b0000};
    vecs[5] = '{OP_ADD, 0, 0, 1'b0, 1, 32'h0000_007F, 32'h0000_0001, 32'h0000_0080, 4'b0110};
    vecs[6] = '{OP_XOR, 2, 2, 1'b0, 2, 32'h00A5_A5A5, 32'h005A_5A00, 32'h00FF_FFA5, 4'b0100};
    vecs[7] = '{OP_MOV, 3, 3, 1'b0, 2, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 4'b0000};
    vecs[8] = '{OP_AND, 0, 0, 1'b0, 0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 4'b1000};
    vecs[9] = '{OP_OR,  1, 0, 1'b1, 1, 32'h0000_0001, 32'h0000_0080, 32'h0000_FF81, 4'b0100};

    reset = 1'b1; start = 1'b0; op = '0; len = '0; arg2_len = '0; sext2 = 1'b0;
    update_flags = 1'b0; step_en = 1'b0; data_in1 = '0; data_in2 = '0;
    m_flags = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_counter", counter, 0);
    check("reset_flags", dut_flags(), 4'b0000);
    check("reset_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      v = vecs[i];
      model(v.op, v.len, v.a2len, v.sx, m_flags[0], v.a1, v.a2, mres, mfl);
      do_op(v, 1'b1, got, fl);
      check($sformatf("vec%0d_result", i), got, v.res);
      check($sformatf("vec%0d_flags", i), fl, v.fl);
      check($sformatf("vec%0d_model", i), got, mres);
      m_flags = mfl;
      @(posedge clk); #1;
    end

    // Reset in the middle of a 32-bit ADD (flags currently nonzero).
    v = '{OP_ADD, 3, 3, 1'b0, 0, 32'h1111_1111, 32'h2222_2222, 32'h0, 4'b0};
    begin_op(v, 1'b1, 1'b0);
    run_steps(0, 5, got);
    step_en = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    check("reset_mid_no_done", done, 1'b0);
    @(posedge clk); #1;
    reset   = 1'b0;
    step_en = 1'b0;
    @(negedge clk);
    check("reset_mid_busy", busy, 1'b0);
    check("reset_mid_counter", counter, 0);
    check("reset_mid_flags", dut_flags(), 4'b0000);
    m_flags = '0;
    @(posedge clk); #1;
    v = vecs[0];
    do_op(v, 1'b1, got, fl);
    check("after_reset_result", got, v.res);
    check("after_reset_flags", fl, v.fl);
    m_flags = fl;
    @(posedge clk); #1;

    // Start held high across done: one op, an idle gap, then a fresh op.
    v = vecs[6];
    model(v.op, v.len, v.a2len, v.sx, m_flags[0], v.a1, v.a2, mres, mfl);
    begin_op(v, 1'b1, 1'b1);
    run_steps(0, cur_steps, got);
    @(negedge clk);
    check("hold_gap_busy", busy, 1'b0);
    check("hold_first_result", got, mres);
    check("hold_first_flags", dut_flags(), mfl);
    @(posedge clk); #1;
    start = 1'b0;
    run_steps(0, cur_steps, got);
    @(negedge clk);
    check("hold_second_idle", busy, 1'b0);
    check("hold_second_result", got, mres);
    m_flags = mfl;
    @(posedge clk); #1;

    // Randomized operations against the model.
    for (int n = 0; n < 40; n++) begin
      bit upd;
      v.op    = 3'($urandom_range(0, 7));
      v.len   = $urandom_range(0, MAX_REGS - 1);
      v.a2len = $urandom_range(0, MAX_REGS - 1);
      v.sx    = 1'($urandom);
      v.mode  = 2;
      v.a1    = $urandom;
      v.a2    = $urandom;
      upd     = ($urandom_range(0, 3) != 0);
      model(v.op, v.len, v.a2len, v.sx, m_flags[0], v.a1, v.a2, mres, mfl);
      do_op(v, upd, got, fl);
      if (upd) m_flags = mfl;
      check($sformatf("rand%0d_op%0d_result", n, v.op), got, mres);
      check($sformatf("rand%0d_op%0d_flags", n, v.op), fl, m_flags);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_alu_wide.md
Name: serial_alu_wide

Overview:
Bit-serial ALU that processes one NSHIFT-bit chunk per enabled cycle, LSB first, over a run-time selectable operand length of 1..MAX_REGS registers.
- Successor to the fixed 8/16-bit serial ALU: generalised in chunk width, register width and operand length.
- Adds a start/busy/done handshake, a per-cycle stall input, and a configurable arg2 length with sign/zero extension.
- Sits between the CPU sequencer and the register-file/memory streams. Operands arrive on data_in1/data_in2 and the result leaves on data_out.

Parameters:
NSHIFT, 2, bits processed per step; must divide REG_BITS
REG_BITS, 8, bits per register
MAX_REGS, 4, maximum operand length in registers
LEN_BITS, $clog2(MAX_REGS), width of length fields
CNT_BITS, $clog2(MAX_REGS*REG_BITS/NSHIFT), step counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  begin operation; sampled only when idle
op  input  3  operation code (package encoding)
len  input  LEN_BITS  operand length in registers minus 1
arg2_len  input  LEN_BITS  valid arg2 registers minus 1; clamped to len
sext2  input  1  sign-extend arg2 beyond arg2_len (else zero-extend)
update_flags  input  1  write flags at end of operation
step_en  input  1  consume one chunk this cycle (stall when low)
data_in1  input  NSHIFT  arg1 chunk
data_in2  input  NSHIFT  arg2 chunk
data_out  output  NSHIFT  result chunk (combinational)
out_valid  output  1  busy && step_en
busy  output  1  operation in progress
done  output  1  one-cycle pulse on the last consumed chunk
counter  output  CNT_BITS  current step index
flag_c, flag_v, flag_s, flag_z  output  1 each  condition flags

Behaviour:
- Reset values: state IDLE, counter 0, carry 0, all flags 0, busy 0, done 0.
- States: IDLE, RUN.
  - IDLE -> RUN when start=1. op, len, arg2_len, sext2 and update_flags are latched at this point.
  - In RUN, start is ignored.
- STEPS = (len+1)*REG_BITS/NSHIFT.
  - Each RUN cycle with step_en=1 consumes one chunk and increments counter.
  - The cycle where counter==STEPS-1 and step_en=1 asserts done, clears counter and returns to IDLE.
  - step_en=0 holds all state; out_valid=0.
- Latency: data_out is valid in the same cycle as its input chunk. No pipeline registers.
- Ops:
  - 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 MOV (result = arg2).
  - SUB/SBC use arg1 + ~arg2 + cin.
- Carry-in at step 0: ADD=0, SUB=1, ADC/SBC=flag_c. Later steps use the internal carry register, updated every consumed step.
- arg2 extension:
  - Chunks at step >= (arg2_len+1)*REG_BITS/NSHIFT are replaced by all-copies of the last valid arg2 MSB if sext2, else 0.
  - data_in2 is ignored in those cycles.
- Flags are written only on the done cycle, and only if update_flags:
  - C = adder carry out of the MSB; 1 means no borrow on SUB. Logic ops and MOV clear C.
  - V = signed overflow of the top chunk; logic ops and MOV clear V.
  - S = result MSB.
  - Z = 1 iff every result chunk of the operation was zero. Zero accumulation runs every step, seeded at step 0.
- Simultaneous start and done: done completes the current op; start is not accepted that cycle (IDLE is reached next cycle).
- Reset mid-operation: immediate return to IDLE, flags cleared, no done pulse.
- len=0 with NSHIFT=REG_BITS: single-step op; done asserts in the same cycle as the first step_en.

Decomposition:
- alu_pkg holds: op encodings (OP_ADD..OP_MOV), helpers op_is_arith, op_uses_carry and op_is_sub, and a flag-index typedef.
- One sub-module, serial_alu_slice: combinational NSHIFT-bit adder/logic slice with carry-out and signed-overflow outputs. The top holds the FSM, counter, extension and flags.

Test Plan (NSHIFT=2, REG_BITS=8):
- ADD, len=1, arg1=0x12FF, arg2=0x0001, step_en=1 throughout -> data_out stream 0x1300; done at cycle 8; C=0, V=0, S=0, Z=0.
- SUB, len=3, both args 0xDEADBEEF -> result 0; Z=1, C=1, V=0. Then SBC, len=0, 0x00-0x00 with flag_c=1 -> 0x00, C=1.
- ADD, len=1, arg2_len=0, sext2=1, arg1=0x0100, arg2 byte 0x80 -> 0x0080, C=1. Same with sext2=0 -> 0x0180, C=0.
- ADD 0x7F+0x01, len=0, with step_en toggling 1,0,1,0 -> result 0x80 over 8 cycles; done exactly once; V=1, S=1; counter frozen while stalled.
- XOR, len=2, with start held high across done -> one op only; busy drops for at least one cycle; second start accepted from IDLE.
- Assert reset at counter=5 of a 32-bit ADD -> busy=0 and all flags 0 next cycle, no done; a fresh op afterwards completes correctly.
